// File: rtl/uart_pkg.sv
// Shared UART framing definitions: state codes, sync marker, frame geometry.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PAYLOAD = 4'd1,
    ST_CHECK   = 4'd2
  } frame_state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF     = 8'hA5;
  localparam int unsigned PAYLOAD_BYTES_DEF = 5;
  // sync + payload + checksum
  localparam int unsigned FRAME_BYTES_DEF   = PAYLOAD_BYTES_DEF + 2;

  // Increment an 8-bit counter, sticking at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/edge_strobe.sv
// Rising-edge detector: turns a level input into a one-cycle pulse.
module edge_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_q;

  // Remember the previous level of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed command receiver: SYNC, payload bytes (LSB first), XOR checksum.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned PAYLOAD_BYTES  = PAYLOAD_BYTES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_done,
  input  logic [7:0]                 read_data,
  output logic [PAYLOAD_BYTES*8-1:0] data,
  output logic                       data_valid,
  output logic                       frame_err,
  output logic [7:0]                 err_cnt,
  output logic [3:0]                 sta
);

  localparam int unsigned IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int unsigned GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  frame_state_e               state;
  logic [IDX_W-1:0]           idx;
  logic [7:0]                 csum;
  logic [PAYLOAD_BYTES*8-1:0] shadow;
  logic [GAP_W-1:0]           gap;
  logic                       acc;
  logic                       tmo;

  edge_strobe u_acc (
    .clk   (clk),
    .rst_n (rst),
    .din   (read_done),
    .pulse (acc)
  );

  assign tmo = (state != ST_IDLE) && (gap == GAP_W'(TIMEOUT_CYCLES - 1));
  assign sta = state;

  // Inter-byte gap counter: held at zero while idle, restarted by every byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                gap <= '0;
    else if (state == ST_IDLE || acc || tmo) gap <= '0;
    else                                     gap <= gap + GAP_W'(1);
  end

  // Frame FSM with registered payload, strobes and error count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      csum       <= '0;
      shadow     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc && read_data == SYNC_BYTE) begin
            state <= ST_PAYLOAD;
            idx   <= '0;
            csum  <= '0;
          end
        end
        ST_PAYLOAD: begin
          // A byte arriving on the timeout cycle takes priority over the timeout.
          if (acc) begin
            shadow[{idx, 3'b000} +: 8] <= read_data;
            csum  <= csum ^ read_data;
            idx   <= idx + IDX_W'(1);
            if (idx == IDX_W'(PAYLOAD_BYTES - 1)) state <= ST_CHECK;
          end else if (tmo) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
            shadow    <= '0;
            state     <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (acc) begin
            if (read_data == csum) begin
              data       <= shadow;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_cnt   <= sat_inc8(err_cnt);
            end
            state <= ST_IDLE;
          end else if (tmo) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
            shadow    <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with a short timeout.
module tb_uart_frame_rx;

  logic        clk;
  logic        rst;
  logic        read_done;
  logic [7:0]  read_data;
  logic [39:0] data;
  logic        data_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic [3:0]  sta;

  int checks   = 0;
  int failures = 0;
  int dv_cycles = 0;
  int fe_cycles = 0;
  logic last_dv, last_fe;
  int first_fe;

  uart_frame_rx #(
    .SYNC_BYTE      (8'hA5),
    .PAYLOAD_BYTES  (5),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_done  (read_done),
    .read_data  (read_data),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .sta        (sta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_cycles++;
    if (frame_err === 1'b1)  fe_cycles++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller sits just after a rising edge; one-cycle strobe, then one low cycle.
  task automatic send_byte(input logic [7:0] b);
    read_data = b;
    read_done = 1'b1;
    @(posedge clk); #1 read_done = 1'b0;
    @(negedge clk);
    last_dv = data_valid;
    last_fe = frame_err;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, ck);
    send_byte(8'hA5);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
    send_byte(ck);
  endtask

  initial begin
    int dv0, fe0;
    rst = 1'b0; read_done = 1'b0; read_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 64'(data), 64'h0);
    chk("rst_dv", 64'(data_valid), 64'h0);
    chk("rst_fe", 64'(frame_err), 64'h0);
    chk("rst_errcnt", 64'(err_cnt), 64'h0);
    chk("rst_sta", 64'(sta), 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Good frame
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01);
    chk("good_dv_pulse", 64'(last_dv), 64'h1);
    chk("good_data", 64'(data), 64'h0504030201);
    chk("good_errcnt", 64'(err_cnt), 64'h0);
    chk("good_dv_one_cycle", 64'(dv_cycles), 64'd1);
    chk("good_sta_idle", 64'(sta), 64'h0);

    // Bad checksum
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF);
    chk("bad_fe_pulse", 64'(last_fe), 64'h1);
    chk("bad_errcnt", 64'(err_cnt), 64'h1);
    chk("bad_data_kept", 64'(data), 64'h0504030201);
    chk("bad_no_dv", 64'(dv_cycles), 64'd1);
    chk("bad_fe_one_cycle", 64'(fe_cycles), 64'd1);

    // Junk then sync and a frame
    send_byte(8'h00); send_byte(8'h7E);
    chk("junk_sta_idle", 64'(sta), 64'h0);
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h10);
    chk("junk_dv", 64'(last_dv), 64'h1);
    chk("junk_data", 64'(data), 64'h5040302010);
    chk("junk_errcnt", 64'(err_cnt), 64'h1);

    // SYNC value inside the payload is plain data
    send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5);
    chk("sync_in_payload", 64'(data), 64'h00000000A5);

    // Timeout: last acc is in cycle 0; terminal count in cycle 100, error seen in cycle 101
    send_byte(8'hA5); send_byte(8'h11);
    chk("tmo_sta_payload", 64'(sta), 64'h1);
    send_byte(8'h22);
    first_fe = -1;
    for (int n = 2; n < 160; n++) begin
      @(negedge clk);
      if (frame_err === 1'b1 && first_fe < 0) first_fe = n;
    end
    @(posedge clk); #1;
    chk("tmo_cycle", 64'(first_fe), 64'd101);
    chk("tmo_errcnt", 64'(err_cnt), 64'h2);
    chk("tmo_sta_idle", 64'(sta), 64'h0);
    chk("tmo_data_kept", 64'(data), 64'h00000000A5);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01);
    chk("tmo_next_data", 64'(data), 64'h0504030201);

    // Byte landing exactly on the terminal-count cycle is processed
    send_byte(8'hA5);
    fe0 = fe_cycles;
    repeat (98) @(posedge clk);
    #1;
    read_data = 8'h0A; read_done = 1'b1;
    @(posedge clk); #1 read_done = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D); send_byte(8'h0E);
    send_byte(8'h0A ^ 8'h0B ^ 8'h0C ^ 8'h0D ^ 8'h0E);
    chk("race_no_err", 64'(fe_cycles - fe0), 64'd0);
    chk("race_data", 64'(data), 64'h0E0D0C0B0A);

    // Held strobe counts one byte
    dv0 = dv_cycles;
    send_byte(8'hA5);
    read_data = 8'h11; read_done = 1'b1;
    repeat (20) @(posedge clk);
    #1 read_done = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    send_byte(8'h11);
    chk("held_dv", 64'(dv_cycles - dv0), 64'd1);
    chk("held_data", 64'(data), 64'h5544332211);
    chk("held_errcnt", 64'(err_cnt), 64'h2);

    // Async reset mid-payload
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    #2 rst = 1'b0;
    #1;
    chk("arst_data", 64'(data), 64'h0);
    chk("arst_errcnt", 64'(err_cnt), 64'h0);
    chk("arst_sta", 64'(sta), 64'h0);
    chk("arst_dv", 64'(data_valid), 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'h21 ^ 8'h43 ^ 8'h65 ^ 8'h87 ^ 8'hA9);
    chk("arst_next_data", 64'(data), 64'hA987654321);
    chk("arst_next_errcnt", 64'(err_cnt), 64'h0);

    // Error counter saturation
    for (int i = 0; i < 254; i++) send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF);
    chk("sat_254", 64'(err_cnt), 64'd254);
    for (int i = 0; i < 46; i++) send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF);
    chk("sat_300", 64'(err_cnt), 64'd255);
    chk("sat_data_kept", 64'(data), 64'hA987654321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
